// File: rtl/pcm_sample_fifo_if.sv
// pcm_sample_fifo_if: sample write strobe and host read handshake.
// master drives the sample strobe and read request; slave is the FIFO.
interface pcm_sample_fifo_if #(
  parameter int unsigned DW = 16
);
  logic          ce_pcm;
  logic [DW-1:0] pcm_in;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (
    output ce_pcm,
    output pcm_in,
    output rd_en,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  ce_pcm,
    input  pcm_in,
    input  rd_en,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: capture FIFO behind the FIR filter with threshold irq,
// sticky overflow and an optional peak-magnitude tracker.
// Optional feature macro: PCM_FIFO_PEAK_EN (peak register; tied to 0 otherwise).
module pcm_sample_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pcm_sample_fifo_if.slave     bus,
  input  logic                 clear,
  output logic [AW:0]          level,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  input  logic [DW-2:0]        thr,
  input  logic                 irq_en,
  output logic                 irq_thr,
  output logic [DW-2:0]        peak
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned MW = DW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          thr_hit;

  logic          rd_acc_c;
  logic          wr_acc_c;
  logic          drop_c;
  logic [CW-1:0] level_nxt_c;
  logic [DW-1:0] abs_c;
  logic [MW-1:0] mag_c;
  logic          hit_c;

  // Accept/drop decisions; a full FIFO still takes a sample if a read frees a slot.
  always_comb begin
    rd_acc_c = bus.rd_en & ~empty;
    wr_acc_c = bus.ce_pcm & (~full | bus.rd_en);
    drop_c   = bus.ce_pcm & full & ~bus.rd_en;
  end

  // Occupancy after this cycle's accepted read/write.
  always_comb begin
    level_nxt_c = level;
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   level_nxt_c = level + CW'(1);
      2'b01:   level_nxt_c = level - CW'(1);
      default: level_nxt_c = level;
    endcase
  end

  // Saturating magnitude: only the most negative code overflows the abs, giving MSB=1.
  always_comb begin
    abs_c = bus.pcm_in[DW-1] ? (~bus.pcm_in + DW'(1)) : bus.pcm_in;
    mag_c = abs_c[DW-1] ? {MW{1'b1}} : abs_c[MW-1:0];
    hit_c = bus.ce_pcm & (mag_c >= thr);
  end

  // Sample storage; contents are deliberately not flushed by clear/reset.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_acc_c) begin
      mem[wp] <= bus.pcm_in;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc_c) wp <= wp + AW'(1);
      if (rd_acc_c) rp <= rp + AW'(1);
      level <= level_nxt_c;
      empty <= (level_nxt_c == CW'(0));
      full  <= (level_nxt_c == CW'(DEPTH));
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Read data path: clear kills the pulse but keeps the last data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else if (clear) begin
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc_c;
      if (rd_acc_c) bus.rd_data <= mem[rp];
    end
  end

  // Sticky threshold hit and its registered, enable-gated interrupt.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      thr_hit <= 1'b0;
      irq_thr <= 1'b0;
    end else begin
      thr_hit <= thr_hit | hit_c;
      irq_thr <= (thr_hit | hit_c) & irq_en;
    end
  end

`ifdef PCM_FIFO_PEAK_EN
  // Peak magnitude since the last clear, including dropped samples.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak <= '0;
    end else if (bus.ce_pcm && (mag_c > peak)) begin
      peak <= mag_c;
    end
  end
`else
  assign peak = '0;
`endif

endmodule

// File: doc/pcm_sample_fifo.md
# pcm_sample_fifo

Capture buffer that sits directly downstream of `FIR_Filter` in the microphone chain. On every `ce_pcm` strobe it stores the signed 16-bit filter output into a small synchronous FIFO, so the host side can drain samples at its own pace. It also raises a threshold interrupt on large-magnitude samples and keeps a sticky overflow flag. Optionally, it tracks a peak-magnitude register.

## Interface
Parameters:
- `DW`, 16, sample width (signed two's complement).
- `DEPTH`, 16, FIFO depth in entries; must be a power of two, at least 2.
- `AW`, 4, address width; must equal log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce_pcm`  in  1  one-cycle sample strobe from `pcm_clk`.
- `pcm_in`  in  DW  signed sample (`fir_out`); valid in the cycle `ce_pcm`=1.
- `clear`  in  1  synchronous flush of FIFO, flags and peak.
- `rd_en`  in  1  read request.
- `rd_data`  out  DW  registered read data.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid in the same cycle.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `empty`  out  1  level==0.
- `full`  out  1  level==DEPTH.
- `overflow`  out  1  sticky; a sample was dropped.
- `thr`  in  DW-1  unsigned magnitude threshold.
- `irq_en`  in  1  interrupt enable.
- `irq_thr`  out  1  sticky threshold interrupt, gated by `irq_en`.
- `peak`  out  DW-1  peak magnitude since clear (see Configuration).

## Operation
- Storage: DEPTH×DW register array. Write pointer and read pointer are AW bits each and wrap modulo DEPTH. An AW+1-bit count drives `level`, `empty` and `full`.
- Write: accepted when `ce_pcm`=1 and (not `full`, or `full` with a same-cycle accepted read). The sample goes to `mem[wp]` and `wp` increments.
- Drop: `ce_pcm`=1 while `full` and no read in that cycle. The sample is discarded, `overflow` is set to 1, and FIFO contents are unchanged.
- Read: accepted when `rd_en`=1 and not `empty`. `rd_data` takes `mem[rp]`, `rp` increments, and `rd_valid`=1 on the next cycle.
  - `rd_en` while `empty` is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
  - A read while `empty` with a same-cycle write is also ignored; the write is accepted.
- Simultaneous accepted read and write: `level` is unchanged.
- Magnitude: `mag` = |`pcm_in`|, computed in DW bits. -32768 saturates to 32767. `mag` is evaluated on every `ce_pcm`, including dropped samples.
- Threshold: if `ce_pcm` and `mag` ≥ `thr`, the internal `thr_hit` flag is set (sticky). `irq_thr` = `thr_hit` & `irq_en`. Toggling `irq_en` does not clear `thr_hit`.
- Clear: `clear`=1 zeroes `wp`, `rp`, count, `overflow`, `thr_hit` and `peak`.
  - `clear` has priority over a write or read in the same cycle; both are discarded and `rd_valid` is 0.
  - `rd_data` holds its value; memory contents are not cleared.
- Reset: same effect as `clear`, plus `rd_data`=0.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `irq_thr`=0, `peak`=0.
- `ce_pcm` in cycle n: `level`/`empty`/`full` update at n+1; `irq_thr` and `overflow` assert at n+1.
- `rd_en` accepted in cycle n: `rd_valid`=1 and `rd_data` valid at n+1 only; `level` updates at n+1.
- Back-to-back reads: one read per cycle, no bubbles.
- Write-to-read latency: a sample written in cycle n can be read with `rd_en` at n+1, giving data at n+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PCM_FIFO_PEAK_EN` defined: the `peak` register updates on every `ce_pcm` where `mag` > `peak` (at n+1). It is zeroed by `clear` or `rst`.
- `PCM_FIFO_PEAK_EN` undefined: the peak logic is not compiled and `peak` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then write 3 samples (100, -200, 300) on separate `ce_pcm` strobes, then 3 `rd_en` cycles → `rd_data` is 100, -200, 300 on consecutive `rd_valid` pulses; `level` goes 3 → 0; `empty`=1.
- Write 17 samples with no reads, DEPTH=16 → `full`=1 after the 16th; `overflow`=1 one cycle after the 17th; draining returns samples 1..16 in order.
- Hold `full`, then pulse `ce_pcm` together with `rd_en` → write accepted, `level` stays 16, `overflow` stays 0.
- `thr`=1000, `irq_en`=1; samples 999 then -1000 → `irq_thr` is 0 after 999 and 1 one cycle after -1000. Sample -32768 with `thr`=32767 → `irq_thr`=1. `clear` → `irq_thr`=0.
- `rd_en` while `empty` for 5 cycles → no `rd_valid`, `level` stays 0. `clear` asserted in the same cycle as `ce_pcm` and `rd_en` with `level`=4 → `level`=0, `rd_valid`=0.
- With `PCM_FIFO_PEAK_EN`: samples 50, -700, 300 → `peak`=700; after `clear` → `peak`=0. Without the macro → `peak`=0 throughout.
